// File: rtl/sdfm_arb_pkg.sv
// sdfm_arb_pkg: shared types, widths and helpers for the SDFM FIFO arbiter
// and its round-robin picker.
package sdfm_arb_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2
   } arb_state_e;

   // Stream word width and per-channel FIFO word-count width.
   localparam int SDFM_DATA_W = 32;
   localparam int SDFM_STAT_W = 4;

   // Words granted to one burst: whatever the FIFO holds, capped at burst_max.
   function automatic logic [SDFM_STAT_W-1:0] sdfm_burst_len(
      input logic [SDFM_STAT_W-1:0] stat,
      input logic [SDFM_STAT_W-1:0] burst_max
   );
      return (stat > burst_max) ? burst_max : stat;
   endfunction

endpackage

// File: rtl/sdfm_fifo_arbiter_if.sv
// sdfm_fifo_arbiter_if: channel-FIFO side and tagged-stream side of the SDFM
// FIFO arbiter. The master modport is the arbiter; the slave modport is the
// environment (FIFOs plus stream consumer). NCH must match the arbiter's NCH.
interface sdfm_fifo_arbiter_if #(
   parameter int NCH = 4
);
   import sdfm_arb_pkg::*;

   localparam int CHW = $clog2(NCH);

   // Channel FIFO side.
   logic [NCH-1:0]             fifo_lvlup;
   logic [NCH-1:0]             fifo_full;
   logic [NCH*SDFM_STAT_W-1:0] fifo_stat;
   logic [NCH*SDFM_DATA_W-1:0] fifo_data;
   logic [NCH-1:0]             fifo_rd;

   // Stream side.
   logic [SDFM_DATA_W-1:0]     out_data;
   logic [CHW-1:0]             out_ch;
   logic                       out_last;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      input  fifo_lvlup,
      input  fifo_full,
      input  fifo_stat,
      input  fifo_data,
      output fifo_rd,
      output out_data,
      output out_ch,
      output out_last,
      output out_valid,
      input  out_ready
   );

   modport slave (
      output fifo_lvlup,
      output fifo_full,
      output fifo_stat,
      output fifo_data,
      input  fifo_rd,
      input  out_data,
      input  out_ch,
      input  out_last,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/sdfm_rr_pick.sv
// sdfm_rr_pick: combinational round-robin picker. Searches req starting at rr
// and wrapping modulo NCH. When any requester is also flagged in prio, only
// prioritised requesters are considered, still in round-robin order from rr.
module sdfm_rr_pick #(
   parameter int NCH = 4
)
(
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] rr,
   input  logic [NCH-1:0]         prio,
   output logic [$clog2(NCH)-1:0] grant,
   output logic                   any
);

   localparam int CHW = $clog2(NCH);

   logic [NCH-1:0] cand;

   // Narrow the candidate set to prioritised requesters when there are any.
   always_comb begin
      cand = ((req & prio) != '0) ? (req & prio) : req;
   end

   // First candidate found walking forward from rr wins.
   always_comb begin
      logic found;
      int   idx;
      // NOTE: every output gets a default before the search so no latch is inferred.
      found = 1'b0;
      grant = '0;
      any   = |req;
      for (int i = 0; i < NCH; i++) begin
         idx = int'(rr) + i;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (!found && cand[idx[CHW-1:0]]) begin
            found = 1'b1;
            grant = CHW'(idx);
         end
      end
   end

endmodule

// File: rtl/sdfm_fifo_arbiter.sv
// sdfm_fifo_arbiter: drains up to NCH channel FIFOs onto one 32-bit
// valid/ready stream tagged with the channel number. Channels share the
// stream in round-robin bursts of at most BURST_MAX words; each word is
// fetched with a one-cycle fifo_rd pulse and then held until handshaken.
// Optional feature macro: SDFM_ARB_FULLPRIO_EN -- a requesting channel whose
// FIFO is full wins over the plain round-robin choice.
module sdfm_fifo_arbiter
   import sdfm_arb_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int BURST_MAX = 8
)
(
   input  logic                SYSCLK,
   input  logic                SYSRST,
   input  logic                reg_arben,
   input  logic [NCH-1:0]      reg_chmask,
   sdfm_fifo_arbiter_if.master bus,
   output logic                arb_busy,
   output logic                arb_abort
);

   localparam int                     CHW         = $clog2(NCH);
   localparam logic [CHW-1:0]         CH_LAST     = CHW'(NCH - 1);
   localparam logic [SDFM_STAT_W-1:0] BURST_LIMIT = SDFM_STAT_W'(BURST_MAX);

   // Per-channel views of the flat FIFO buses.
   logic [SDFM_STAT_W-1:0] stat_a [NCH];
   logic [SDFM_DATA_W-1:0] data_a [NCH];
   logic [NCH-1:0]         req;
   logic [NCH-1:0]         prio;

   // Picker results.
   logic [CHW-1:0]         pick_ch;
   logic                   pick_any;
   logic [SDFM_STAT_W-1:0] pick_len;

   // Registered state and its next values.
   arb_state_e             state_q, state_d;
   logic [CHW-1:0]         ch_q, ch_d;
   logic [SDFM_STAT_W-1:0] rem_q, rem_d;
   logic [CHW-1:0]         rr_q, rr_d;
   logic [SDFM_DATA_W-1:0] out_data_q, out_data_d;
   logic [CHW-1:0]         out_ch_q, out_ch_d;
   logic                   out_last_q, out_last_d;
   logic                   out_valid_q, out_valid_d;

   // Combinational strobes, only meaningful outside reset.
   logic [NCH-1:0]         rd_d;
   logic                   abort_d;

   // Helpers for the granted channel.
   logic [CHW-1:0]         ch_after;
   logic                   ch_empty;
   logic                   handshake;

   // Unpack the FIFO buses and form the request vector; an empty FIFO never
   // requests even when its level flag is set (level 0 reads as reached).
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         stat_a[k] = bus.fifo_stat[k*SDFM_STAT_W +: SDFM_STAT_W];
         data_a[k] = bus.fifo_data[k*SDFM_DATA_W +: SDFM_DATA_W];
         req[k]    = reg_arben & reg_chmask[k] & bus.fifo_lvlup[k]
                     & (stat_a[k] != '0);
      end
   end

`ifdef SDFM_ARB_FULLPRIO_EN
   // Full FIFOs jump the queue; round-robin order still applies among them.
   assign prio = bus.fifo_full & req;
`else
   // Pure round-robin; the full flags are not consulted.
   logic unused_full;
   assign prio        = '0;
   assign unused_full = ^bus.fifo_full;
`endif

   sdfm_rr_pick #(
      .NCH (NCH)
   ) u_pick (
      .req   (req),
      .rr    (rr_q),
      .prio  (prio),
      .grant (pick_ch),
      .any   (pick_any)
   );

   assign pick_len  = sdfm_burst_len(stat_a[pick_ch], BURST_LIMIT);
   assign ch_after  = (ch_q == CH_LAST) ? '0 : ch_q + CHW'(1);
   assign ch_empty  = (stat_a[ch_q] == '0);
   assign handshake = out_valid_q & bus.out_ready;

   // Next-state and strobe logic for the IDLE / READ / SEND sequence.
   always_comb begin
      // NOTE: every signal written here is defaulted first; without it any
      // path that skips an assignment would infer a latch.
      state_d     = state_q;
      ch_d        = ch_q;
      rem_d       = rem_q;
      rr_d        = rr_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      rd_d        = '0;
      abort_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               ch_d    = pick_ch;
               rem_d   = pick_len;
               state_d = READ;
            end
         end

         READ: begin
            // fifo_stat here already reflects the previous pop, so a FIFO that
            // was disabled or drained mid-burst shows up as zero.
            if (!reg_arben || ch_empty) begin
               abort_d = 1'b1;
               rr_d    = ch_after;
               state_d = IDLE;
            end else begin
               rd_d[ch_q]  = 1'b1;
               out_data_d  = data_a[ch_q];
               out_ch_d    = ch_q;
               out_last_d  = (rem_q == SDFM_STAT_W'(1));
               out_valid_d = 1'b1;
               rem_d       = rem_q - SDFM_STAT_W'(1);
               state_d     = SEND;
            end
         end

         SEND: begin
            // Word and tag are held untouched until the consumer takes them.
            if (handshake) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  rr_d    = ch_after;
                  state_d = IDLE;
               end else if (!reg_arben) begin
                  abort_d = 1'b1;
                  rr_d    = ch_after;
                  state_d = IDLE;
               end else begin
                  state_d = READ;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and stream registers with synchronous active-high reset.
   always_ff @(posedge SYSCLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values computed above.
      if (SYSRST) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         rem_q       <= '0;
         rr_q        <= '0;
         // NOTE: the stream data register is reset too so the outputs leave
         // reset at zero rather than with whatever word was last captured.
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         rem_q       <= rem_d;
         rr_q        <= rr_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Strobes are blanked while reset is asserted so a burst cut by reset
   // never pops a FIFO word.
   assign bus.fifo_rd   = SYSRST ? '0 : rd_d;
   assign arb_abort     = ~SYSRST & abort_d;
   assign arb_busy      = ~SYSRST & (state_q != IDLE);

   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sdfm_fifo_arbiter.sv
// tb_sdfm_fifo_arbiter: self-checking bench for sdfm_fifo_arbiter. The FIFOs
// are queues inside the bench; a burst-level reference model predicts every
// fifo_rd, arb_abort, arb_busy and stream word each cycle, and directed
// scenarios pin the model with hand-computed expectations.
module tb_sdfm_fifo_arbiter;
   import sdfm_arb_pkg::*;

   localparam int NCH  = 4;
   localparam int BMAX = 8;
   localparam int CHW  = $clog2(NCH);

`ifdef SDFM_ARB_FULLPRIO_EN
   localparam bit FULLPRIO = 1'b1;
`else
   localparam bit FULLPRIO = 1'b0;
`endif

   logic           SYSCLK = 1'b0;
   logic           SYSRST = 1'b1;
   logic           reg_arben = 1'b0;
   logic [NCH-1:0] reg_chmask = '0;
   logic           arb_busy;
   logic           arb_abort;

   sdfm_fifo_arbiter_if #(.NCH(NCH)) bus ();

   sdfm_fifo_arbiter #(
      .NCH       (NCH),
      .BURST_MAX (BMAX)
   ) dut (
      .SYSCLK     (SYSCLK),
      .SYSRST     (SYSRST),
      .reg_arben  (reg_arben),
      .reg_chmask (reg_chmask),
      .bus        (bus),
      .arb_busy   (arb_busy),
      .arb_abort  (arb_abort)
   );

   always #5 SYSCLK = ~SYSCLK;

   // Environment: FIFO contents, level flags and per-FIFO enable.
   logic [31:0]    q [NCH][$];
   logic [NCH-1:0] lvl = '0;
   logic [NCH-1:0] en  = '1;
   logic [NCH-1:0] pend_pop = '0;

   // Bookkeeping.
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int abort_cnt = 0;
   int busy_cnt  = 0;
   int          hs_ch   [$];
   logic        hs_last [$];
   logic [31:0] hs_data [$];
   int          rd_cyc  [$];
   int          rd_ch   [$];

   // Reference model state (burst level).
   logic        m_valid = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_hold  = 1'b0;
   logic        m_last  = 1'b0;
   int          m_ch    = 0;
   int          m_left  = 0;
   int          m_ptr   = 0;
   logic [31:0] m_data  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model_pick(input logic [NCH-1:0] req, input logic [NCH-1:0] full,
                                     input int ptr);
      int j;
      if (FULLPRIO) begin
         for (int i = 0; i < NCH; i++) begin
            j = (ptr + i) % NCH;
            if (req[j] && full[j]) return j;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         j = (ptr + i) % NCH;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   task automatic drive_env();
      int sz;
      for (int k = 0; k < NCH; k++) begin
         sz = q[k].size();
         bus.fifo_stat[k*4 +: 4]   = en[k] ? 4'((sz > 15) ? 15 : sz) : 4'd0;
         bus.fifo_data[k*32 +: 32] = (sz > 0) ? q[k][0] : (32'hDEAD_0000 | 32'(k));
         bus.fifo_full[k]          = (sz >= 15);
         bus.fifo_lvlup[k]         = lvl[k];
      end
   endtask

   // Called at the falling edge: log activity, compare DUT with the model,
   // then advance the model to what the next rising edge must produce.
   task automatic model_step();
      int             st [NCH];
      logic [NCH-1:0] req;
      logic [NCH-1:0] e_rd;
      logic           e_ab, e_busy;
      logic           n_busy, n_hold, n_last;
      int             n_ch, n_left, n_ptr, c;
      logic [31:0]    n_data;

      for (int k = 0; k < NCH; k++) begin
         if (bus.fifo_rd[k] === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_ch.push_back(k);
         end
      end
      if (arb_abort === 1'b1) abort_cnt++;
      if (arb_busy === 1'b1) busy_cnt++;
      if (bus.out_valid === 1'b1 && bus.out_ready && !SYSRST) begin
         hs_ch.push_back(int'(bus.out_ch));
         hs_last.push_back(bus.out_last);
         hs_data.push_back(bus.out_data);
      end
      pend_pop = bus.fifo_rd;
      cyc++;
      if (!m_valid && !SYSRST) return;

      for (int k = 0; k < NCH; k++) begin
         st[k]  = int'(bus.fifo_stat[k*4 +: 4]);
         req[k] = reg_arben && reg_chmask[k] && bus.fifo_lvlup[k] && (st[k] != 0);
      end
      e_rd = '0;  e_ab = 1'b0;  e_busy = m_busy;
      n_busy = m_busy;  n_hold = m_hold;  n_last = m_last;
      n_ch = m_ch;  n_left = m_left;  n_ptr = m_ptr;  n_data = m_data;

      if (SYSRST) begin
         e_busy = 1'b0;  n_busy = 1'b0;  n_hold = 1'b0;  n_last = 1'b0;
         n_ptr = 0;  n_left = 0;  n_data = '0;
      end else if (!m_busy) begin
         c = model_pick(req, bus.fifo_full, m_ptr);
         if (c >= 0) begin
            n_busy = 1'b1;
            n_ch   = c;
            n_left = (st[c] < BMAX) ? st[c] : BMAX;
         end
      end else if (!m_hold) begin
         if (!reg_arben || st[m_ch] == 0) begin
            e_ab = 1'b1;  n_busy = 1'b0;  n_ptr = (m_ch + 1) % NCH;
         end else begin
            e_rd[m_ch] = 1'b1;
            n_hold = 1'b1;
            n_data = bus.fifo_data[m_ch*32 +: 32];
            n_last = (m_left == 1);
            n_left = m_left - 1;
         end
      end else if (bus.out_ready) begin
         n_hold = 1'b0;
         if (m_last) begin
            n_busy = 1'b0;  n_ptr = (m_ch + 1) % NCH;
         end else if (!reg_arben) begin
            e_ab = 1'b1;  n_busy = 1'b0;  n_ptr = (m_ch + 1) % NCH;
         end
      end

      if (m_valid) begin
         check("fifo_rd",   32'(bus.fifo_rd),   32'(e_rd));
         check("arb_abort", 32'(arb_abort),     32'(e_ab));
         check("arb_busy",  32'(arb_busy),      32'(e_busy));
         check("out_valid", 32'(bus.out_valid), 32'(m_hold));
         if (m_hold) begin
            check("out_data", bus.out_data,        m_data);
            check("out_ch",   32'(bus.out_ch),     32'(m_ch));
            check("out_last", 32'(bus.out_last),   32'(m_last));
         end
      end

      m_busy = n_busy;  m_hold = n_hold;  m_last = n_last;  m_ch = n_ch;
      m_left = n_left;  m_ptr = n_ptr;    m_data = n_data;
      if (SYSRST) m_valid = 1'b1;
   endtask

   task automatic tick();
      @(negedge SYSCLK);
      model_step();
      @(posedge SYSCLK);
      #1;
      for (int k = 0; k < NCH; k++) begin
         if (pend_pop[k] && q[k].size() > 0) void'(q[k].pop_front());
      end
      drive_env();
   endtask

   task automatic push_words(input int ch, input int n);
      for (int i = 0; i < n; i++) q[ch].push_back($urandom);
      drive_env();
   endtask

   task automatic do_reset();
      SYSRST = 1'b1;
      for (int k = 0; k < NCH; k++) q[k].delete();
      lvl = '0;  en = '1;  reg_arben = 1'b1;  reg_chmask = '1;  bus.out_ready = 1'b1;
      drive_env();
      tick();
      tick();
      SYSRST = 1'b0;
      drive_env();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  bus.out_data,       32'd0);
      check("rst_out_ch",    32'(bus.out_ch),    32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_arb_busy",  32'(arb_busy),      32'd0);
      check("rst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
   endtask

   // Tick until `target` handshakes have been logged in total, or budget expires.
   task automatic wait_hs(input string name, input int target, input int budget);
      for (int i = 0; i < budget && hs_ch.size() < target; i++) tick();
      check(name, 32'(hs_ch.size() >= target), 32'd1);
   endtask

   initial begin
      int          h0, r0, a0, b0, c0, exp_first;
      int          exp_seq [$];
      logic [31:0] words [$];
      logic [31:0] held;

      // Single channel drain: three words, reads two cycles apart.
      do_reset();
      h0 = hs_ch.size();  r0 = rd_ch.size();
      push_words(1, 3);
      lvl[1] = 1'b1;
      drive_env();
      wait_hs("drain_done", h0 + 3, 40);
      check("drain_busy_low", 32'(arb_busy), 32'd0);
      check("drain_rd_count", 32'(rd_ch.size() - r0), 32'd3);
      for (int i = 0; i < 3 && r0 + i < rd_ch.size(); i++)
         check("drain_rd_ch", 32'(rd_ch[r0+i]), 32'd1);
      for (int i = 1; i < 3 && r0 + i < rd_cyc.size(); i++)
         check("drain_rd_gap", 32'(rd_cyc[r0+i] - rd_cyc[r0+i-1]), 32'd2);
      for (int i = 0; i < 3 && h0 + i < hs_ch.size(); i++) begin
         check("drain_out_ch",   32'(hs_ch[h0+i]),   32'd1);
         check("drain_out_last", 32'(hs_last[h0+i]), 32'(i == 2));
      end

      // Round-robin between ch0 and ch2, ten words each.
      do_reset();
      h0 = hs_ch.size();
      push_words(0, 10);
      push_words(2, 10);
      lvl[0] = 1'b1;  lvl[2] = 1'b1;
      drive_env();
      repeat (8) exp_seq.push_back(0);
      repeat (8) exp_seq.push_back(2);
      repeat (2) exp_seq.push_back(0);
      repeat (2) exp_seq.push_back(2);
      wait_hs("rr_done", h0 + 20, 200);
      for (int i = 0; i < 20 && h0 + i < hs_ch.size(); i++) begin
         check("rr_order", 32'(hs_ch[h0+i]), 32'(exp_seq[i]));
         check("rr_last",  32'(hs_last[h0+i]), 32'(i == 7 || i == 15 || i == 17 || i == 19));
      end

      // Backpressure: first word held for five cycles with no further reads.
      do_reset();
      h0 = hs_ch.size();
      bus.out_ready = 1'b0;
      push_words(2, 4);
      words = q[2];
      lvl[2] = 1'b1;
      drive_env();
      for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) tick();
      check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
      held = bus.out_data;
      r0 = rd_ch.size();
      check("bp_first_word", held, words[0]);
      repeat (5) begin
         tick();
         check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
         check("bp_data_hold",  bus.out_data, held);
         check("bp_no_read",    32'(rd_ch.size()), 32'(r0));
      end
      bus.out_ready = 1'b1;
      wait_hs("bp_done", h0 + 4, 40);
      for (int i = 0; i < 4 && h0 + i < hs_data.size(); i++)
         check("bp_words", hs_data[h0+i], words[i]);

      // Early abort: ch1 disabled after two of five words.
      do_reset();
      h0 = hs_ch.size();  a0 = abort_cnt;
      push_words(1, 5);
      push_words(2, 3);
      lvl[1] = 1'b1;  lvl[2] = 1'b1;
      drive_env();
      r0 = rd_ch.size();
      wait_hs("abort_two_words", h0 + 2, 40);
      en[1] = 1'b0;
      drive_env();
      wait_hs("abort_next_burst", h0 + 5, 60);
      check("abort_pulses", 32'(abort_cnt - a0), 32'd1);
      c0 = 0;
      for (int i = r0; i < rd_ch.size(); i++) if (rd_ch[i] == 1) c0++;
      check("abort_ch1_reads", 32'(c0), 32'd2);
      for (int i = 0; i < 2 && h0 + i < hs_ch.size(); i++)
         check("abort_no_last", 32'(hs_last[h0+i]), 32'd0);
      if (h0 + 2 < hs_ch.size()) check("abort_next_ch", 32'(hs_ch[h0+2]), 32'd2);
      en[1] = 1'b1;
      drive_env();
      wait_hs("abort_resume", h0 + 8, 60);
      if (h0 + 5 < hs_ch.size()) check("abort_resume_ch", 32'(hs_ch[h0+5]), 32'd1);

      // Level reached on an empty FIFO must not grant.
      do_reset();
      b0 = busy_cnt;  r0 = rd_ch.size();
      lvl = '1;
      drive_env();
      repeat (12) tick();
      check("empty_busy_cycles", 32'(busy_cnt - b0), 32'd0);
      check("empty_reads",       32'(rd_ch.size() - r0), 32'd0);

      // Full-priority: ch0 holds 4 words, ch3 is full.
      do_reset();
      h0 = hs_ch.size();
      push_words(0, 4);
      push_words(3, 15);
      lvl[0] = 1'b1;  lvl[3] = 1'b1;
      drive_env();
      exp_first = FULLPRIO ? 3 : 0;
      wait_hs("fullprio_grant", h0 + 1, 20);
      if (h0 < hs_ch.size()) check("fullprio_first_ch", 32'(hs_ch[h0]), 32'(exp_first));

      // Randomized traffic against the model.
      do_reset();
      lvl = '1;
      for (int n = 0; n < 3000; n++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         reg_arben     = ($urandom_range(0, 31) != 0);
         if ($urandom_range(0, 63) == 0) reg_chmask = NCH'($urandom);
         if ($urandom_range(0, 15) == 0) lvl[$urandom_range(0, NCH-1)] = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NCH; k++) begin
            if ($urandom_range(0, 7) == 0 && q[k].size() < 20) q[k].push_back($urandom);
            if ($urandom_range(0, 199) == 0) en[k] = ~en[k];
         end
         SYSRST = ($urandom_range(0, 499) == 0);
         drive_env();
         tick();
      end
      SYSRST = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sdfm_fifo_arbiter.md
# sdfm_fifo_arbiter

Drains up to NCH per-channel filter-data FIFOs onto a single 32-bit stream with a valid/ready handshake, tagging each word with its channel number. It sits between the channel FIFOs and the bus/DMA-side consumer. It sequences FIFO reads by issuing one-cycle `fifo_rd` pulses, and shares the output between channels using round-robin bursts.

## Interface
- NCH, 4: number of channels (2..8).
- BURST_MAX, 8: maximum words transferred per grant (1..15).
- SYSCLK  in  1  system clock; all logic on its rising edge.
- SYSRST  in  1  synchronous, active-high reset.
- reg_arben  in  1  arbiter enable.
- reg_chmask  in  NCH  per-channel service enable.
- fifo_lvlup  in  NCH  per-channel FIFO level-reached flag.
- fifo_full  in  NCH  per-channel FIFO full flag.
- fifo_stat  in  NCH*4  per-channel FIFO word count; channel k occupies bits [4k+3:4k].
- fifo_data  in  NCH*32  per-channel FIFO head word, combinational from the FIFO.
- fifo_rd  out  NCH  one-hot, one-cycle read pulse; the FIFO pops at the end of that cycle.
- out_data  out  32  stream data.
- out_ch  out  $clog2(NCH)  channel tag for out_data.
- out_last  out  1  last word of the current burst.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- arb_busy  out  1  high when not in IDLE.
- arb_abort  out  1  one-cycle pulse when a burst ends early.

## Operation
- Request vector: req[k] = reg_arben & reg_chmask[k] & fifo_lvlup[k] & (fifo_stat[k] != 0). The non-zero check is required because lvlup is true on an empty FIFO when its level is 0.
- Round-robin pointer rr:
  - Search starts at rr and wraps modulo NCH.
  - On burst end (normal or abort), rr ← granted channel + 1, mod NCH.
- FSM states IDLE, READ, SEND:
  - **IDLE:** if any req is set:
    - Latch ch = picked channel.
    - Latch rem = min(fifo_stat[ch], BURST_MAX).
    - Go to READ.
  - **READ:**
    - If !reg_arben or fifo_stat[ch] == 0: pulse arb_abort, no read, go to IDLE.
    - Otherwise:
      - Assert fifo_rd[ch].
      - Register out_data ← fifo_data[ch], out_ch ← ch, out_last ← (rem == 1), out_valid ← 1.
      - rem ← rem − 1.
      - Go to SEND.
  - **SEND:** hold out_data, out_ch, out_last and out_valid stable until out_valid & out_ready. On the handshake, out_valid ← 0, then:
    - If out_last: go to IDLE.
    - Else if !reg_arben: pulse arb_abort, go to IDLE.
    - Else: go to READ.
- Latched rem is safe because only this block pops the FIFO. Writes into the FIFO during a burst only raise fifo_stat.
- A FIFO disabled mid-burst makes fifo_stat 0. This is caught in READ and aborts; the previous word's out_last stays 0.
- Reset values:
  - All outputs 0.
  - rr = 0, state = IDLE, rem = 0.
  - Reset mid-burst drops any un-handshaken word; no fifo_rd is issued.

## Timing
- Request seen in IDLE at cycle t:
  - t+1: READ, fifo_rd[ch] high.
  - t+2: out_valid high with the popped word.
- Throughput: one word per 2 cycles with out_ready held high (READ/SEND alternate).
- fifo_stat is sampled in READ at least one cycle after the previous fifo_rd, so it already reflects the previous pop.
- Gap between bursts: at least 1 IDLE cycle.
- out_valid never drops without a handshake; out_data, out_ch and out_last do not change while out_valid & !out_ready.
- fifo_rd is never asserted in IDLE or SEND, and never more than 1 bit at a time.

## Configuration
- SDFM_ARB_FULLPRIO_EN:
  - **Defined:** in IDLE, any channel with fifo_full & req set wins over the round-robin choice. Among several full channels, round-robin order from rr applies. The grant burst length is still min(stat, BURST_MAX).
  - **Undefined:** fifo_full is ignored (the port remains) and arbitration is pure round-robin.

## Structure
- Package `sdfm_arb_pkg`:
  - State enum {IDLE, READ, SEND}.
  - SDFM_DATA_W = 32.
  - SDFM_STAT_W = 4.
- Sub-module `sdfm_rr_pick`:
  - Inputs: req[NCH], rr pointer, and an optional priority mask.
  - Outputs: grant index and any-request flag.
  - Purely combinational; reused by other arbiters.

## Test plan
- **Single channel drain:** ch1 stat=3, lvlup=1, out_ready=1.
  - Expect three fifo_rd[1] pulses 2 cycles apart.
  - Three words with out_ch=1; out_last only on the third.
  - arb_busy falls after the last handshake.
- **Round-robin:** ch0 and ch2 each stat=10, BURST_MAX=8.
  - Expect grant order ch0(8 words), ch2(8), ch0(2), ch2(2).
  - rr wraps correctly.
- **Backpressure:** out_ready=0 for 5 cycles after the first word.
  - out_valid stays 1 with stable out_data.
  - No further fifo_rd until the handshake.
- **Early abort:** stat forced to 0 after word 2 of a 5-word burst.
  - Expect an arb_abort pulse and no third fifo_rd.
  - out_last never asserted; next grant goes to ch+1.
- **Empty with level 0:** lvlup=1, stat=0 → no grant, arb_busy stays 0.
- **Full priority (macro defined):** rr=0, ch0 stat=4 and ch3 full (stat=15).
  - Expect the first grant to ch3.
  - With the macro undefined, expect the first grant to ch0.
